// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sequencer: operator encodings, FSM states, error codes.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package calc_pkg;

  // One-hot operator encodings as presented by the keypad and driven to the arithmetic unit
  localparam logic [3:0] OP_NONE = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_MUL  = 4'b0100;
  localparam logic [3:0] OP_DIV  = 4'b1000;

  // Error codes reported while in ST_ERROR
  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_OVF     = 2'd1;
  localparam logic [1:0] ERR_DIV0    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    ST_ENTER_A,
    ST_ENTER_B,
    ST_ISSUE,
    ST_WAIT,
    ST_RESULT,
    ST_ERROR
  } state_t;

  // An operator strobe is usable only when exactly one bit is set
  function automatic logic op_is_valid(input logic [3:0] op);
    return $onehot(op);
  endfunction

endpackage

// File: rtl/calc_digit_accum.sv
// Decimal operand accumulator: magnitude, sign and digit count of the operand being keyed in.
// Latency: accept/reject and next signed value are combinational; state updates on the next clk edge.
// Backpressure: none; digits that would exceed the digit count or the positive range are flagged as rejected.
module calc_digit_accum #(
  parameter int WIDTH      = 16,
  parameter int MAX_DIGITS = 5
) (
  input  logic                    clk,
  input  logic                    nRST,
  input  logic                    clr,
  input  logic                    digit_vld,
  input  logic [3:0]              digit_in,
  input  logic                    neg_in,
  output logic                    digit_ok,
  output logic                    digit_rej,
  output logic                    has_digit_nxt,
  output logic signed [WIDTH-1:0] value_nxt
);

  localparam int CW = $clog2(MAX_DIGITS + 1);
  // Extra headroom so mag*10+9 never wraps before the range comparison
  localparam int EW = WIDTH + 4;
  localparam logic [EW-1:0] MAX_MAG = EW'((64'd1 << (WIDTH - 1)) - 64'd1);

  logic [WIDTH-2:0] mag_q;
  logic             sign_q;
  logic [CW-1:0]    cnt_q;

  logic [EW-1:0]    cand;
  logic             fits;
  logic [WIDTH-2:0] mag_n;
  logic [CW-1:0]    cnt_n;
  logic             sign_n;
  logic [WIDTH-1:0] mag_ext;

  // Digit first, then sign toggle: this is the operand an operator/equals in the same cycle commits
  always_comb begin
    cand          = EW'(mag_q) * EW'(10) + EW'(digit_in);
    fits          = (digit_in <= 4'd9) && (cnt_q < CW'(MAX_DIGITS)) && (cand <= MAX_MAG);
    digit_ok      = digit_vld & fits;
    digit_rej     = digit_vld & ~fits;
    mag_n         = digit_ok ? cand[WIDTH-2:0] : mag_q;
    cnt_n         = digit_ok ? cnt_q + CW'(1) : cnt_q;
    sign_n        = sign_q ^ neg_in;
    has_digit_nxt = (cnt_n != '0);
    mag_ext       = {1'b0, mag_n};
    value_nxt     = sign_n ? -$signed(mag_ext) : $signed(mag_ext);
  end

  // Operand state; cleared whenever the owning FSM commits the operand
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      mag_q  <= '0;
      sign_q <= 1'b0;
      cnt_q  <= '0;
    end else if (clr) begin
      mag_q  <= '0;
      sign_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      mag_q  <= mag_n;
      sign_q <= sign_n;
      cnt_q  <= cnt_n;
    end
  end

endmodule

// File: rtl/calc_seq_ctrl.sv
// Calculator sequencer: keypad operand/operator entry, one start/done operation per evaluation, result display.
// Latency: op_start one cycle after equal_in; complete one cycle after op_done; all outputs registered.
// Backpressure: waits on op_done up to TIMEOUT cycles; keys not usable in the current state pulse key_reject.
module calc_seq_ctrl
  import calc_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int MAX_DIGITS = 5,
  parameter int TIMEOUT    = 64
) (
  input  logic                    clk,
  input  logic                    nRST,
  input  logic [3:0]              digit_in,
  input  logic                    digit_vld,
  input  logic [3:0]              op_in,
  input  logic                    neg_in,
  input  logic                    equal_in,
  input  logic                    clear_in,
  output logic                    op_start,
  output logic [3:0]              op_code,
  output logic signed [WIDTH-1:0] op_a,
  output logic signed [WIDTH-1:0] op_b,
  input  logic                    op_done,
  input  logic signed [WIDTH-1:0] op_result,
  input  logic                    op_ovf,
  output logic signed [WIDTH-1:0] display_value,
  output logic                    complete,
  output logic                    key_reject,
  output logic                    error,
  output logic [1:0]              err_code
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t                  state;
  logic signed [WIDTH-1:0] res_q;
  logic [TW-1:0]           tcnt;

  logic                    op_any, op_ok, op_bad;
  logic                    in_entry;
  logic                    acc_dvld, acc_neg, acc_clr;
  logic                    acc_ok, acc_rej, has_digit_nxt;
  logic signed [WIDTH-1:0] value_nxt;
  logic                    b_replace;
  logic                    key_rej_nxt;

  assign op_any    = (op_in != OP_NONE);
  assign op_ok     = op_is_valid(op_in);
  assign op_bad    = op_any & ~op_ok;
  assign in_entry  = (state == ST_ENTER_A) || (state == ST_ENTER_B);
  // A digit keyed in RESULT starts a fresh A operand, so the accumulator listens there too
  assign acc_dvld  = digit_vld & (in_entry || (state == ST_RESULT));
  assign acc_neg   = neg_in & in_entry;
  // Operator before any B digit just swaps the pending operator
  assign b_replace = (state == ST_ENTER_B) && op_ok && !has_digit_nxt;

  calc_digit_accum #(
    .WIDTH      (WIDTH),
    .MAX_DIGITS (MAX_DIGITS)
  ) u_accum (
    .clk           (clk),
    .nRST          (nRST),
    .clr           (acc_clr),
    .digit_vld     (acc_dvld),
    .digit_in      (digit_in),
    .neg_in        (acc_neg),
    .digit_ok      (acc_ok),
    .digit_rej     (acc_rej),
    .has_digit_nxt (has_digit_nxt),
    .value_nxt     (value_nxt)
  );

  // Decide which keys are dropped this cycle and when the entry operand is consumed
  always_comb begin
    key_rej_nxt = 1'b0;
    acc_clr     = clear_in;
    if (!clear_in) begin
      case (state)
        ST_ENTER_A: begin
          key_rej_nxt = acc_rej | op_bad | equal_in;
          acc_clr     = op_ok;
        end
        ST_ENTER_B: begin
          key_rej_nxt = acc_rej | (op_any & ~b_replace);
          acc_clr     = equal_in & ~b_replace;
        end
        ST_RESULT: key_rej_nxt = acc_rej | neg_in | op_bad;
        default:   key_rej_nxt = digit_vld | op_any | neg_in | equal_in;
      endcase
    end
  end

  // Main sequencer: entry, issue, wait with timeout, result chaining and error hold
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state         <= ST_ENTER_A;
      op_start      <= 1'b0;
      op_code       <= OP_NONE;
      op_a          <= '0;
      op_b          <= '0;
      res_q         <= '0;
      tcnt          <= '0;
      display_value <= '0;
      complete      <= 1'b0;
      key_reject    <= 1'b0;
      error         <= 1'b0;
      err_code      <= ERR_NONE;
    end else begin
      op_start   <= 1'b0;
      complete   <= 1'b0;
      key_reject <= key_rej_nxt;
      if (clear_in) begin
        state         <= ST_ENTER_A;
        op_code       <= OP_NONE;
        op_a          <= '0;
        op_b          <= '0;
        res_q         <= '0;
        tcnt          <= '0;
        display_value <= '0;
        error         <= 1'b0;
        err_code      <= ERR_NONE;
      end else begin
        case (state)
          ST_ENTER_A: begin
            if (op_ok) begin
              op_a          <= value_nxt;
              op_code       <= op_in;
              display_value <= '0;
              state         <= ST_ENTER_B;
            end else begin
              display_value <= value_nxt;
            end
          end
          ST_ENTER_B: begin
            if (b_replace) begin
              op_code       <= op_in;
              display_value <= value_nxt;
            end else if (equal_in) begin
              if ((op_code == OP_DIV) && (value_nxt == '0)) begin
                error         <= 1'b1;
                err_code      <= ERR_DIV0;
                display_value <= '0;
                state         <= ST_ERROR;
              end else begin
                op_b     <= value_nxt;
                op_start <= 1'b1;
                state    <= ST_ISSUE;
              end
            end else begin
              display_value <= value_nxt;
            end
          end
          ST_ISSUE: begin
            tcnt  <= '0;
            state <= ST_WAIT;
          end
          ST_WAIT: begin
            if (op_done) begin
              if (op_ovf) begin
                error         <= 1'b1;
                err_code      <= ERR_OVF;
                display_value <= '0;
                state         <= ST_ERROR;
              end else begin
                res_q         <= op_result;
                display_value <= op_result;
                complete      <= 1'b1;
                state         <= ST_RESULT;
              end
            end else if (tcnt == TW'(TIMEOUT - 1)) begin
              error         <= 1'b1;
              err_code      <= ERR_TIMEOUT;
              display_value <= '0;
              state         <= ST_ERROR;
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
          ST_RESULT: begin
            if (acc_ok) begin
              display_value <= value_nxt;
              state         <= ST_ENTER_A;
            end else if (op_ok) begin
              op_a          <= res_q;
              op_code       <= op_in;
              display_value <= '0;
              state         <= ST_ENTER_B;
            end else if (equal_in) begin
              op_a     <= res_q;
              op_start <= 1'b1;
              state    <= ST_ISSUE;
            end
          end
          ST_ERROR: begin
            display_value <= '0;
          end
          default: state <= ST_ENTER_A;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Bench for calc_seq_ctrl: keystroke tables with expected display/reject, plus issue/response sequences.
// Inputs change on the falling edge; outputs are sampled on the following falling edge.
// Issued operations are queued when equals is keyed and checked when op_start appears.
module tb_calc_seq_ctrl;

  localparam int W  = 16;
  localparam int TO = 16;

  logic                clk = 1'b0;
  logic                nRST;
  logic [3:0]          digit_in;
  logic                digit_vld;
  logic [3:0]          op_in;
  logic                neg_in, equal_in, clear_in;
  logic                op_start;
  logic [3:0]          op_code;
  logic signed [W-1:0] op_a, op_b;
  logic                op_done;
  logic signed [W-1:0] op_result;
  logic                op_ovf;
  logic signed [W-1:0] display_value;
  logic                complete, key_reject, error;
  logic [1:0]          err_code;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       dv;
    logic [3:0] d;
    logic       neg;
    logic [3:0] op;
    logic       eq;
    logic       clr;
    int         exp_disp;
    logic       exp_rej;
  } vec_t;

  typedef struct {
    logic [3:0] code;
    int         a;
    int         b;
  } iss_t;

  vec_t vt[$];
  iss_t sb[$];

  always #5 clk = ~clk;

  calc_seq_ctrl #(.WIDTH(W), .MAX_DIGITS(5), .TIMEOUT(TO)) dut (
    .clk(clk), .nRST(nRST), .digit_in(digit_in), .digit_vld(digit_vld), .op_in(op_in),
    .neg_in(neg_in), .equal_in(equal_in), .clear_in(clear_in), .op_start(op_start),
    .op_code(op_code), .op_a(op_a), .op_b(op_b), .op_done(op_done), .op_result(op_result),
    .op_ovf(op_ovf), .display_value(display_value), .complete(complete),
    .key_reject(key_reject), .error(error), .err_code(err_code)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic dv, input logic [3:0] d, input logic neg, input logic [3:0] op,
                              input logic eq, input logic clr, input int disp, input logic rej);
    vec_t v;
    v.dv = dv; v.d = d; v.neg = neg; v.op = op; v.eq = eq; v.clr = clr;
    v.exp_disp = disp; v.exp_rej = rej;
    return v;
  endfunction

  function automatic int calc(input logic [3:0] c, input int a, input int b);
    case (c)
      4'b0001: return a + b;
      4'b0010: return a - b;
      4'b0100: return a * b;
      4'b1000: return (b != 0) ? a / b : 0;
      default: return 0;
    endcase
  endfunction

  // One keystroke cycle; returns on the falling edge after the sampling edge
  task automatic press(input logic dv, input logic [3:0] d, input logic neg, input logic [3:0] op,
                       input logic eq, input logic clr);
    @(negedge clk);
    digit_vld = dv; digit_in = d; neg_in = neg; op_in = op; equal_in = eq; clear_in = clr;
    @(negedge clk);
    digit_vld = 1'b0; digit_in = 4'd0; neg_in = 1'b0; op_in = 4'd0; equal_in = 1'b0; clear_in = 1'b0;
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      press(vt[i].dv, vt[i].d, vt[i].neg, vt[i].op, vt[i].eq, vt[i].clr);
      chk($sformatf("vec%0d_display", i), display_value, vt[i].exp_disp);
      chk($sformatf("vec%0d_reject", i), key_reject, vt[i].exp_rej);
    end
  endtask

  // Key equals, expect the queued operation on op_start in the very next cycle, exactly one cycle wide
  task automatic equal_issue(input string nm, input logic [3:0] code, input int a, input int b, output iss_t got);
    iss_t e;
    int   lat;
    e.code = code; e.a = a; e.b = b;
    sb.push_back(e);
    press(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0);
    lat = 0;
    while (!op_start && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, "_start_latency"}, lat, 0);
    got = sb.pop_front();
    chk({nm, "_op_code"}, op_code, got.code);
    chk({nm, "_op_a"}, op_a, got.a);
    chk({nm, "_op_b"}, op_b, got.b);
    @(negedge clk);
    chk({nm, "_start_width"}, op_start, 0);
  endtask

  task automatic respond(input int res, input logic ovf, input int dly);
    repeat (dly) @(negedge clk);
    op_done = 1'b1; op_result = W'(res); op_ovf = ovf;
    @(negedge clk);
    op_done = 1'b0; op_result = '0; op_ovf = 1'b0;
  endtask

  task automatic serve_ok(input string nm, input iss_t it);
    int r;
    r = int'($signed(W'(calc(it.code, it.a, it.b))));
    respond(r, 1'b0, 2);
    chk({nm, "_complete"}, complete, 1);
    chk({nm, "_display"}, display_value, r);
    @(negedge clk);
    chk({nm, "_complete_width"}, complete, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    iss_t it;
    int   n;
    logic seen;

    // Group 1: 1,2,3 ADD 4,5
    vt.push_back(mk(0, 0, 0, 4'b0000, 0, 1, 0, 0));
    vt.push_back(mk(1, 1, 0, 4'b0000, 0, 0, 1, 0));
    vt.push_back(mk(1, 2, 0, 4'b0000, 0, 0, 12, 0));
    vt.push_back(mk(1, 3, 0, 4'b0000, 0, 0, 123, 0));
    vt.push_back(mk(0, 0, 0, 4'b0001, 0, 0, 0, 0));
    vt.push_back(mk(1, 4, 0, 4'b0000, 0, 0, 4, 0));
    vt.push_back(mk(1, 5, 0, 4'b0000, 0, 0, 45, 0));                    // idx 6
    // Group 2: range limit and sign
    vt.push_back(mk(0, 0, 0, 4'b0000, 0, 1, 0, 0));                     // idx 7
    vt.push_back(mk(1, 3, 0, 4'b0000, 0, 0, 3, 0));
    vt.push_back(mk(1, 2, 0, 4'b0000, 0, 0, 32, 0));
    vt.push_back(mk(1, 7, 0, 4'b0000, 0, 0, 327, 0));
    vt.push_back(mk(1, 6, 0, 4'b0000, 0, 0, 3276, 0));
    vt.push_back(mk(1, 8, 0, 4'b0000, 0, 0, 3276, 1));
    vt.push_back(mk(0, 0, 1, 4'b0000, 0, 0, -3276, 0));
    vt.push_back(mk(1, 9, 0, 4'b0000, 0, 0, -3276, 1));                 // idx 14
    // Group 3: bad keys, digit count limit, operator replacement
    vt.push_back(mk(0, 0, 0, 4'b0000, 0, 1, 0, 0));                     // idx 15
    vt.push_back(mk(1, 10, 0, 4'b0000, 0, 0, 0, 1));
    vt.push_back(mk(0, 0, 0, 4'b0000, 1, 0, 0, 1));
    vt.push_back(mk(0, 0, 0, 4'b0011, 0, 0, 0, 1));
    vt.push_back(mk(1, 0, 0, 4'b0000, 0, 0, 0, 0));
    vt.push_back(mk(1, 0, 0, 4'b0000, 0, 0, 0, 0));
    vt.push_back(mk(1, 0, 0, 4'b0000, 0, 0, 0, 0));
    vt.push_back(mk(1, 0, 0, 4'b0000, 0, 0, 0, 0));
    vt.push_back(mk(1, 1, 0, 4'b0000, 0, 0, 1, 0));
    vt.push_back(mk(1, 2, 0, 4'b0000, 0, 0, 1, 1));
    vt.push_back(mk(0, 0, 1, 4'b0000, 0, 0, -1, 0));
    vt.push_back(mk(0, 0, 0, 4'b0010, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 4'b0001, 0, 0, 0, 0));
    vt.push_back(mk(1, 7, 0, 4'b0000, 0, 0, 7, 0));
    vt.push_back(mk(0, 0, 0, 4'b0100, 0, 0, 7, 1));                     // idx 29

    nRST = 1'b0;
    digit_vld = 1'b0; digit_in = 4'd0; op_in = 4'd0; neg_in = 1'b0; equal_in = 1'b0; clear_in = 1'b0;
    op_done = 1'b0; op_result = '0; op_ovf = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_op_start", op_start, 0);
    chk("rst_complete", complete, 0);
    chk("rst_key_reject", key_reject, 0);
    chk("rst_error", error, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_display", display_value, 0);
    chk("rst_op_a", op_a, 0);
    chk("rst_op_b", op_b, 0);
    chk("rst_op_code", op_code, 0);
    nRST = 1'b1;
    @(negedge clk);
    chk("post_rst_display", display_value, 0);

    // 123 + 45 = 168, then chain * 2 and repeat-equals
    run_vecs(0, 6);
    equal_issue("add", 4'b0001, 123, 45, it);
    serve_ok("add", it);
    press(0, 0, 0, 4'b0100, 0, 0);
    chk("chain_display", display_value, 0);
    chk("chain_reject", key_reject, 0);
    press(1, 2, 0, 4'b0000, 0, 0);
    chk("chain_b_display", display_value, 2);
    equal_issue("mul", 4'b0100, 168, 2, it);
    serve_ok("mul", it);
    equal_issue("rep", 4'b0100, 336, 2, it);
    serve_ok("rep", it);

    run_vecs(7, 14);
    run_vecs(15, 29);
    equal_issue("neg_add", 4'b0001, -1, 7, it);
    serve_ok("neg_add", it);
    press(0, 0, 1, 4'b0000, 0, 0);
    chk("result_neg_reject", key_reject, 1);
    chk("result_neg_display", display_value, 6);
    press(1, 9, 0, 4'b0000, 0, 0);
    chk("result_digit_display", display_value, 9);
    chk("result_digit_reject", key_reject, 0);

    // Divide by zero goes straight to error without an issue
    press(0, 0, 0, 4'b0000, 0, 1);
    press(1, 7, 0, 4'b0000, 0, 0);
    press(0, 0, 0, 4'b1000, 0, 0);
    press(1, 0, 0, 4'b0000, 0, 0);
    seen = op_start;
    press(0, 0, 0, 4'b0000, 1, 0);
    for (int i = 0; i < 4; i++) begin
      seen = seen | op_start;
      @(negedge clk);
    end
    chk("div0_no_start", seen, 0);
    chk("div0_error", error, 1);
    chk("div0_err_code", err_code, 2);
    chk("div0_display", display_value, 0);
    press(1, 5, 0, 4'b0000, 0, 0);
    chk("err_digit_reject", key_reject, 1);
    chk("err_digit_display", display_value, 0);
    chk("err_hold_code", err_code, 2);
    press(0, 0, 0, 4'b0000, 0, 1);
    chk("clr_error", error, 0);
    chk("clr_err_code", err_code, 0);
    chk("clr_display", display_value, 0);
    chk("clr_op_a", op_a, 0);
    chk("clr_op_code", op_code, 0);

    // Timeout while op_done is withheld, then a late op_done is ignored
    press(1, 1, 0, 4'b0000, 0, 0);
    press(0, 0, 0, 4'b0001, 0, 0);
    press(1, 1, 0, 4'b0000, 0, 0);
    equal_issue("to", 4'b0001, 1, 1, it);
    n = 0;
    while (!error && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_window", int'(n >= TO - 1 && n <= TO + 2), 1);
    chk("timeout_err_code", err_code, 3);
    chk("timeout_display", display_value, 0);
    respond(2, 1'b0, 1);
    chk("late_done_complete", complete, 0);
    chk("late_done_err_code", err_code, 3);
    chk("late_done_display", display_value, 0);

    // Overflow reported with op_done
    press(0, 0, 0, 4'b0000, 0, 1);
    press(1, 9, 0, 4'b0000, 0, 0);
    press(0, 0, 0, 4'b0100, 0, 0);
    press(1, 9, 0, 4'b0000, 0, 0);
    equal_issue("ovf", 4'b0100, 9, 9, it);
    respond(81, 1'b1, 2);
    chk("ovf_complete", complete, 0);
    chk("ovf_error", error, 1);
    chk("ovf_err_code", err_code, 1);

    // Asynchronous reset while op_start is high, then a stray op_done
    press(0, 0, 0, 4'b0000, 0, 1);
    press(1, 2, 0, 4'b0000, 0, 0);
    press(0, 0, 0, 4'b0001, 0, 0);
    press(1, 3, 0, 4'b0000, 0, 0);
    press(0, 0, 0, 4'b0000, 1, 0);
    chk("arst_pre_start", op_start, 1);
    #2;
    nRST = 1'b0;
    #1;
    chk("arst_op_start", op_start, 0);
    chk("arst_complete", complete, 0);
    chk("arst_error", error, 0);
    chk("arst_op_a", op_a, 0);
    @(negedge clk);
    nRST = 1'b1;
    respond(5, 1'b0, 1);
    chk("arst_late_complete", complete, 0);
    chk("arst_late_display", display_value, 0);
    press(1, 4, 0, 4'b0000, 0, 0);
    chk("arst_enter_a_display", display_value, 4);
    chk("arst_enter_a_reject", key_reject, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
